// File: rtl/param_processor_pkg.sv
// Shared types for the parametrised processor: opcodes, FSM states, PSR bit
// positions, branch condition codes and instruction field positions.
package proc_pkg;

    typedef enum logic [3:0] {
        OP_NOP        = 4'd0,
        OP_LOAD       = 4'd1,
        OP_STORE      = 4'd2,
        OP_BRANCH     = 4'd3,
        OP_XOR        = 4'd4,
        OP_ADD        = 4'd5,
        OP_ROTATE     = 4'd6,
        OP_SHIFT      = 4'd7,
        OP_HALT       = 4'd8,
        OP_COMPLEMENT = 4'd9
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    localparam int PSR_ZERO   = 4;
    localparam int PSR_NEG    = 3;
    localparam int PSR_EVEN   = 2;
    localparam int PSR_PARITY = 1;
    localparam int PSR_CARRY  = 0;

    localparam logic [3:0] CC_ALWAYS   = 4'd0;
    localparam logic [3:0] CC_PARITY   = 4'd1;
    localparam logic [3:0] CC_EVEN     = 4'd2;
    localparam logic [3:0] CC_CARRY    = 4'd3;
    localparam logic [3:0] CC_NEG      = 4'd4;
    localparam logic [3:0] CC_ZERO     = 4'd5;
    localparam logic [3:0] CC_NOT_CARRY = 4'd6;
    localparam logic [3:0] CC_NOT_NEG  = 4'd7;

    localparam int F_OP_LO    = 28;
    localparam int F_CC_LO    = 24;
    localparam int F_SRC_TYPE = 27;
    localparam int F_SRC_LO   = 12;
    localparam int F_DEST_LO  = 0;

    function automatic logic cond_eval(input logic [3:0] cc, input logic [4:0] psr);
        logic taken;
        taken = 1'b0;
        case (cc)
            CC_ALWAYS:    taken = 1'b1;
            CC_PARITY:    taken = psr[PSR_PARITY];
            CC_EVEN:      taken = psr[PSR_EVEN];
            CC_CARRY:     taken = psr[PSR_CARRY];
            CC_NEG:       taken = psr[PSR_NEG];
            CC_ZERO:      taken = psr[PSR_ZERO];
            CC_NOT_CARRY: taken = !psr[PSR_CARRY];
            CC_NOT_NEG:   taken = !psr[PSR_NEG];
            default:      taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic writes_reg(input logic [3:0] op);
        logic w;
        w = 1'b0;
        case (op)
            OP_LOAD, OP_XOR, OP_ADD, OP_ROTATE, OP_SHIFT, OP_COMPLEMENT: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/param_processor_if.sv
// Program-load, debug-read and status bundle of param_processor.
// The illegal flag exists only when PROC_ILLEGAL_TRAP_EN is defined.
interface param_processor_if #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 64
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic              prg_we;
    logic [AW-1:0]     prg_addr;
    logic [DATA_W-1:0] prg_data;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [AW-1:0]     pc;
    logic [4:0]        psr;
    logic              retire;
    logic              halted;
`ifdef PROC_ILLEGAL_TRAP_EN
    logic              illegal;

    modport master (output prg_we, prg_addr, prg_data, dbg_addr,
                    input  dbg_data, pc, psr, retire, halted, illegal);
    modport slave  (input  prg_we, prg_addr, prg_data, dbg_addr,
                    output dbg_data, pc, psr, retire, halted, illegal);
`else
    modport master (output prg_we, prg_addr, prg_data, dbg_addr,
                    input  dbg_data, pc, psr, retire, halted);
    modport slave  (input  prg_we, prg_addr, prg_data, dbg_addr,
                    output dbg_data, pc, psr, retire, halted);
`endif
endinterface

// File: rtl/param_processor_alu.sv
// Combinational ALU: result and next PSR for the register-writing opcodes.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        i_opcode,
    input  logic [DATA_W-1:0] i_operand,
    input  logic [DATA_W-1:0] i_dest_val,
    input  logic              i_carry,
    output logic [DATA_W-1:0] o_result,
    output logic [4:0]        o_psr
);

    logic [DATA_W:0]   w_sum;
    logic              w_neg_amt;
    logic [DATA_W-1:0] w_mag;
    logic [DATA_W-1:0] w_rot;
    logic [DATA_W-1:0] w_rot_left;
    logic              w_carry;

    always_comb begin
        w_sum     = {1'b0, i_dest_val} + {1'b0, i_operand};
        w_neg_amt = i_operand[DATA_W-1];
        w_mag     = w_neg_amt ? (~i_operand + DATA_W'(1)) : i_operand;
        w_rot     = w_mag % DATA_W'(DATA_W);
        // A right rotate by k is a left rotate by DATA_W-k.
        w_rot_left = (w_neg_amt && (w_rot != '0)) ? (DATA_W'(DATA_W) - w_rot) : w_rot;
        w_carry   = i_carry;
        o_result  = '0;
        case (i_opcode)
            OP_LOAD:       o_result = i_operand;
            OP_XOR:        o_result = i_dest_val ^ i_operand;
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                w_carry  = w_sum[DATA_W];
            end
            OP_ROTATE:     o_result = (i_dest_val << w_rot_left) |
                                      (i_dest_val >> (DATA_W'(DATA_W) - w_rot_left));
            OP_SHIFT: begin
                if (w_mag >= DATA_W'(DATA_W))
                    o_result = '0;
                else if (w_neg_amt)
                    o_result = i_dest_val >> w_mag;
                else
                    o_result = i_dest_val << w_mag;
            end
            OP_COMPLEMENT: o_result = ~i_operand;
            default:       o_result = '0;
        endcase
        o_psr = {(o_result == '0), o_result[DATA_W-1], ~o_result[0], ^o_result, w_carry};
    end

endmodule

// File: rtl/param_processor.sv
// Multi-cycle processor core: FSM, PC, register file and unified memory.
// Optional illegal-opcode trap enabled by defining PROC_ILLEGAL_TRAP_EN.
//   state     | meaning
//   FETCH     | latch instruction fields from mem[pc]
//   DECODE    | read operands; short ops arm retire
//   EXECUTE   | ALU evaluate; NOP/BRANCH/HALT finish here
//   WRITEBACK | commit reg/mem/PSR, pc+1, retire
//   HALTED    | frozen until reset
module param_processor
    import proc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 64,
    parameter int NREGS     = 16,
    parameter int RESET_PC  = 0
) (
    input logic clk,
    input logic reset,
    param_processor_if.slave bus
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int RW = $clog2(NREGS);

    logic [DATA_W-1:0] r_mem  [MEM_DEPTH];
    logic [DATA_W-1:0] r_regs [NREGS];

    state_t            r_state;
    logic [AW-1:0]     r_pc;
    logic [3:0]        r_opcode;
    logic [3:0]        r_cc;
    logic [11:0]       r_src;
    logic [AW-1:0]     r_dest_addr;
    logic [RW-1:0]     r_dest_reg;
    logic [DATA_W-1:0] r_operand;
    logic [DATA_W-1:0] r_dest_val;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_psr;
    logic [4:0]        r_psr_next;
    logic              r_retire;
    logic              r_halted;

    logic              w_src_type;
    logic              w_long_op;
    logic              w_taken;
    logic [DATA_W-1:0] w_operand;
    logic [DATA_W-1:0] w_alu_result;
    logic [4:0]        w_alu_psr;

`ifdef PROC_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_legal;
    assign w_legal     = (r_opcode <= OP_COMPLEMENT);
    assign bus.illegal = r_illegal;
`endif

    assign w_src_type = r_cc[F_SRC_TYPE - F_CC_LO];
    assign w_long_op  = writes_reg(r_opcode) || (r_opcode == OP_STORE);
    assign w_taken    = (r_opcode == OP_BRANCH) && cond_eval(r_cc, r_psr);

    // Shift/rotate immediates are signed amounts; every other immediate is zero-extended.
    always_comb begin
        w_operand = r_regs[r_src[RW-1:0]];
        if (w_src_type) begin
            if ((r_opcode == OP_ROTATE) || (r_opcode == OP_SHIFT))
                w_operand = {{(DATA_W-12){r_src[11]}}, r_src};
            else
                w_operand = {{(DATA_W-12){1'b0}}, r_src};
        end else if (r_opcode == OP_LOAD) begin
            w_operand = r_mem[r_src[AW-1:0]];
        end
    end

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .i_opcode   (r_opcode),
        .i_operand  (r_operand),
        .i_dest_val (r_dest_val),
        .i_carry    (r_psr[PSR_CARRY]),
        .o_result   (w_alu_result),
        .o_psr      (w_alu_psr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            if (bus.prg_we)
                r_mem[bus.prg_addr] <= bus.prg_data;
        end else if ((r_state == S_WRITEBACK) && (r_opcode == OP_STORE)) begin
            r_mem[r_dest_addr] <= r_operand;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_pc        <= AW'(RESET_PC);
            r_opcode    <= '0;
            r_cc        <= '0;
            r_src       <= '0;
            r_dest_addr <= '0;
            r_dest_reg  <= '0;
            r_operand   <= '0;
            r_dest_val  <= '0;
            r_result    <= '0;
            r_psr       <= '0;
            r_psr_next  <= '0;
            r_retire    <= 1'b0;
            r_halted    <= 1'b0;
`ifdef PROC_ILLEGAL_TRAP_EN
            r_illegal   <= 1'b0;
`endif
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_opcode    <= r_mem[r_pc][F_OP_LO +: 4];
                    r_cc        <= r_mem[r_pc][F_CC_LO +: 4];
                    r_src       <= r_mem[r_pc][F_SRC_LO +: 12];
                    r_dest_addr <= r_mem[r_pc][F_DEST_LO +: AW];
                    r_dest_reg  <= r_mem[r_pc][F_DEST_LO +: RW];
                    r_state     <= S_DECODE;
                end
                S_DECODE: begin
                    r_operand  <= w_operand;
                    r_dest_val <= r_regs[r_dest_reg];
`ifdef PROC_ILLEGAL_TRAP_EN
                    r_retire   <= !w_long_op && w_legal;
`else
                    r_retire   <= !w_long_op;
`endif
                    r_state    <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_result   <= w_alu_result;
                    r_psr_next <= w_alu_psr;
                    if (w_long_op) begin
                        r_retire <= 1'b1;
                        r_state  <= S_WRITEBACK;
                    end else if (r_opcode == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALTED;
`ifdef PROC_ILLEGAL_TRAP_EN
                    end else if (!w_legal) begin
                        r_illegal <= 1'b1;
                        r_halted  <= 1'b1;
                        r_state   <= S_HALTED;
`endif
                    end else begin
                        r_pc    <= w_taken ? r_dest_addr : r_pc + AW'(1);
                        r_state <= S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    if (writes_reg(r_opcode)) begin
                        r_regs[r_dest_reg] <= r_result;
                        r_psr              <= r_psr_next;
                    end
                    r_pc    <= r_pc + AW'(1);
                    r_state <= S_FETCH;
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    assign bus.dbg_data = r_mem[bus.dbg_addr];
    assign bus.pc       = r_pc;
    assign bus.psr      = r_psr;
    assign bus.retire   = r_retire;
    assign bus.halted   = r_halted;

endmodule

// File: tb/tb_param_processor.sv
// Directed bench for param_processor: a vector table walks one program
// instruction by instruction, then hand sequences cover halt, reset abort and illegal opcodes.
module tb_param_processor;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    param_processor_if #(.DATA_W(32), .MEM_DEPTH(64)) bus ();

    param_processor #(
        .DATA_W(32), .MEM_DEPTH(64), .NREGS(16), .RESET_PC(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] instr;
        int          lat;
        logic [5:0]  pc;
        logic [4:0]  psr;
        logic        halt;
        int          maddr;
        logic [31:0] mval;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        bus.prg_we   = 1'b1;
        bus.prg_addr = a;
        bus.prg_data = d;
        @(posedge clk); #1;
        bus.prg_we   = 1'b0;
    endtask

    // Counts cycles from the current FETCH up to and including the retire cycle.
    task automatic wait_retire(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.retire !== 1'b1 && n < 20);
    endtask

    task automatic chk_mem(input string name, input logic [5:0] a, input logic [31:0] exp);
        bus.dbg_addr = a;
        #1;
        chk(name, bus.dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int retires;
        logic pc_moved;
        n_checks = 0;
        n_errors = 0;
        reset        = 1'b1;
        bus.prg_we   = 1'b0;
        bus.prg_addr = '0;
        bus.prg_data = '0;
        bus.dbg_addr = '0;

        //            addr   instr          lat pc     psr    halt maddr mval
        vecs.push_back('{6'd0,  32'h18003000, 4, 6'd1,  5'h00, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd1,  32'h18004001, 4, 6'd2,  5'h06, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd2,  32'h50000001, 4, 6'd3,  5'h02, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd3,  32'h20001030, 4, 6'd4,  5'h02, 1'b0, 48, 32'h7});
        vecs.push_back('{6'd4,  32'h10028002, 4, 6'd5,  5'h08, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd5,  32'h58001002, 4, 6'd6,  5'h15, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd6,  32'h35000014, 3, 6'd20, 5'h15, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd20, 32'h3800001E, 3, 6'd21, 5'h15, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd21, 32'h18080003, 4, 6'd22, 5'h07, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd22, 32'h78FFC003, 4, 6'd23, 5'h07, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd23, 32'h20003031, 4, 6'd24, 5'h07, 1'b0, 49, 32'h8});
        vecs.push_back('{6'd24, 32'h18001004, 4, 6'd25, 5'h03, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd25, 32'h68FFF004, 4, 6'd26, 5'h0F, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd26, 32'h68001004, 4, 6'd27, 5'h03, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd27, 32'h20004032, 4, 6'd28, 5'h03, 1'b0, 50, 32'h1});
        vecs.push_back('{6'd28, 32'h78028003, 4, 6'd29, 5'h15, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd29, 32'h48005003, 4, 6'd30, 5'h01, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd30, 32'h35000000, 3, 6'd31, 5'h01, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd31, 32'h30000021, 3, 6'd33, 5'h01, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd33, 32'h98000005, 4, 6'd34, 5'h09, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd34, 32'h20005033, 4, 6'd35, 5'h09, 1'b0, 51, 32'hFFFFFFFF});
        vecs.push_back('{6'd35, 32'h28005024, 4, 6'd36, 5'h09, 1'b0, 36, 32'h5});
        vecs.push_back('{6'd36, 32'h80000000, 3, 6'd37, 5'h09, 1'b0, -1, 32'h0});
        vecs.push_back('{6'd37, 32'h80000000, 3, 6'd37, 5'h09, 1'b1, -1, 32'h0});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", {26'd0, bus.pc}, 32'd0);
        chk("rst_psr", {27'd0, bus.psr}, 32'd0);
        chk("rst_retire", {31'd0, bus.retire}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
`ifdef PROC_ILLEGAL_TRAP_EN
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
`endif

        foreach (vecs[i]) load(vecs[i].addr, vecs[i].instr);
        load(6'd32, 32'h80000000);
        load(6'd40, 32'hFFFFFFFF);
        load(6'd53, 32'h00005555);
        reset = 1'b0;

        foreach (vecs[i]) begin
            wait_retire(n);
            chk($sformatf("lat@%0d", vecs[i].addr), n, vecs[i].lat);
            @(posedge clk); #1;
            chk($sformatf("pc@%0d", vecs[i].addr), {26'd0, bus.pc}, {26'd0, vecs[i].pc});
            chk($sformatf("psr@%0d", vecs[i].addr), {27'd0, bus.psr}, {27'd0, vecs[i].psr});
            chk($sformatf("halted@%0d", vecs[i].addr), {31'd0, bus.halted}, {31'd0, vecs[i].halt});
            if (vecs[i].maddr >= 0)
                chk_mem($sformatf("mem@%0d", vecs[i].addr), 6'(vecs[i].maddr), vecs[i].mval);
        end

        // Halted: PC frozen, no retire, and a load strobe outside reset is ignored.
        retires  = 0;
        pc_moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.retire === 1'b1) retires++;
            if (bus.pc !== 6'd37) pc_moved = 1'b1;
            bus.prg_we   = (i == 5);
            bus.prg_addr = 6'd53;
            bus.prg_data = 32'h0000BEEF;
        end
        bus.prg_we = 1'b0;
        chk("halt_retires", retires, 0);
        chk("halt_pc_moved", {31'd0, pc_moved}, 32'd0);
        chk("halt_still", {31'd0, bus.halted}, 32'd1);
        chk_mem("prg_we_no_reset", 6'd53, 32'h00005555);

        // Second program: reset during a STORE's EXECUTE must abort the write.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        load(6'd0, 32'h28123034);
        load(6'd1, 32'h20001036);
        load(6'd2, 32'hA0000000);
        load(6'd3, 32'h80000000);
        load(6'd52, 32'h0000DEAD);
        load(6'd54, 32'h0000FFFF);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_exec_retire", {31'd0, bus.retire}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pc", {26'd0, bus.pc}, 32'd0);
        chk("abort_psr", {27'd0, bus.psr}, 32'd0);
        chk("abort_halted", {31'd0, bus.halted}, 32'd0);
        chk("abort_retire", {31'd0, bus.retire}, 32'd0);
        chk_mem("abort_mem", 6'd52, 32'h0000DEAD);

        reset = 1'b0;
        wait_retire(n);
        chk("p2_store_lat", n, 4);
        @(posedge clk); #1;
        chk_mem("p2_store_mem", 6'd52, 32'h00000123);
        chk("p2_store_pc", {26'd0, bus.pc}, 32'd1);
        wait_retire(n);
        chk("p2_regclr_lat", n, 4);
        @(posedge clk); #1;
        chk_mem("p2_regs_cleared", 6'd54, 32'h0);

`ifdef PROC_ILLEGAL_TRAP_EN
        retires = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.retire === 1'b1) retires++;
        end
        chk("ill_retires", retires, 0);
        chk("ill_flag", {31'd0, bus.illegal}, 32'd1);
        chk("ill_halted", {31'd0, bus.halted}, 32'd1);
        chk("ill_pc", {26'd0, bus.pc}, 32'd2);
`else
        wait_retire(n);
        chk("ill_nop_lat", n, 3);
        @(posedge clk); #1;
        chk("ill_nop_pc", {26'd0, bus.pc}, 32'd3);
        chk("ill_nop_psr", {27'd0, bus.psr}, 32'd0);
        wait_retire(n);
        chk("p2_halt_lat", n, 3);
        @(posedge clk); #1;
        chk("p2_halted", {31'd0, bus.halted}, 32'd1);
        chk("p2_halt_pc", {26'd0, bus.pc}, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
